cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor: the WIDTH-bit datapath is split into 16-bit CLA slices, one slice per pipeline stage, with the carry forwarded between stages through registers.
- Valid/ready handshake on input and output, with full backpressure (global stall).
- Sits in the ALU datapath where a single-cycle 16-bit CLA no longer meets timing at 32/64 bits.

---
 rtl/cla_pipe_adder.sv | 191 +++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder -- pipelined carry-lookahead adder/subtractor.
//
// The WIDTH-bit datapath is cut into 16-bit carry-lookahead slices, one slice
// per pipeline stage. The carry out of each slice is registered and consumed
// by the next stage. Upper operand bits travel forward with the partial sum.
// Latency is NSLICE cycles and throughput is one operation per cycle. A
// single global stall freezes every stage while the output is blocked.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands valid this cycle
//   in_ready   block can accept operands this cycle (low only while stalled)
//   a, b       WIDTH-bit operands
//   cin        carry-in, used in add mode only
//   sub        0: a + b + cin   1: a - b, computed as a + ~b + 1
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit result, modulo 2^WIDTH
//   cout       carry out of the MSB (in sub mode, 1 means no borrow)
//   ovf        signed overflow: carry into MSB xor carry out of MSB
//   zero       sum == 0
//
// WIDTH must be a multiple of 16 and at least 16.

module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int NSLICE = WIDTH / 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // 16-bit CLA. It uses four 4-bit lookahead groups and a group-level carry
  // generator. Every carry is a flat sum of products, so no carry ripples.
  // The result is {carry_out, sum[15:0]}.
  function automatic logic [16:0] cla16(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic        c);
    logic [15:0] p, g, cc;
    logic [3:0]  gp, gg;
    logic [4:0]  gc;
    int          base;
    p = x ^ y;
    g = x & y;
    for (int j = 0; j < 4; j++) begin
      base  = 4 * j;
      gp[j] = &p[base +: 4];
      gg[j] = g[base+3]
            | (p[base+3] & g[base+2])
            | (p[base+3] & p[base+2] & g[base+1])
            | (p[base+3] & p[base+2] & p[base+1] & g[base]);
    end
    gc[0] = c;
    gc[1] = gg[0] | (gp[0] & c);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c);
    for (int j = 0; j < 4; j++) begin
      base         = 4 * j;
      cc[base]     = gc[j];
      cc[base + 1] = g[base] | (p[base] & gc[j]);
      cc[base + 2] = g[base+1] | (p[base+1] & g[base])
                   | (p[base+1] & p[base] & gc[j]);
      cc[base + 3] = g[base+2] | (p[base+2] & g[base+1])
                   | (p[base+2] & p[base+1] & g[base])
                   | (p[base+2] & p[base+1] & p[base] & gc[j]);
    end
    return {gc[4], p ^ cc};
  endfunction

  logic             stall;
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // This is a global stall. Bubbles are not squeezed out, so a blocked
  // output freezes the whole pipe.
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // Subtraction is done as a + ~b + 1. The caller's cin is ignored here.
  assign b_eff = sub ? ~b : b;
  assign c0    = sub | cin;

  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    // LO is the number of low sum bits that are complete after this stage.
    localparam int LO = 16 * (k + 1);

    logic [15:0]   xa, xb;
    logic          xc, xv;
    logic [16:0]   r;
    logic [LO-1:0] s_n;
    logic [LO-1:0] s_q;
    logic          c_q;
    logic          v_q;

    if (k == 0) begin : g_in
      assign xa  = a[15:0];
      assign xb  = b_eff[15:0];
      assign xc  = c0;
      assign xv  = in_valid;
      assign s_n = r[15:0];
    end else begin : g_in
      assign xa  = g_stage[k-1].g_fwd.a_q[16*k +: 16];
      assign xb  = g_stage[k-1].g_fwd.b_q[16*k +: 16];
      assign xc  = g_stage[k-1].c_q;
      assign xv  = g_stage[k-1].v_q;
      assign s_n = {r[15:0], g_stage[k-1].s_q};
    end

    assign r = cla16(xa, xb, xc);

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= xv;
        c_q <= r[16];
        s_q <= s_n;
      end
    end

    if (k < NSLICE - 1) begin : g_fwd
      // These are the operand bits that later stages still need.
      logic [WIDTH-1:LO] fa, fb;
      logic [WIDTH-1:LO] a_q, b_q;

      if (k == 0) begin : g_src
        assign fa = a[WIDTH-1:16];
        assign fb = b_eff[WIDTH-1:16];
      end else begin : g_src
        assign fa = g_stage[k-1].g_fwd.a_q[WIDTH-1:LO];
        assign fb = g_stage[k-1].g_fwd.b_q[WIDTH-1:LO];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= fa;
          b_q <= fb;
        end
      end
    end else begin : g_last
      logic c15;
      logic ovf_q;
      logic zero_q;

      // Carry into bit 15 of the last slice is recovered from that bit's
      // sum and operands, because s = x ^ y ^ c at every bit position.
      assign c15 = r[15] ^ xa[15] ^ xb[15];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          ovf_q  <= c15 ^ r[16];
          zero_q <= (s_n == '0);
        end
      end
    end
  end

  assign out_valid = g_stage[NSLICE-1].v_q;
  assign sum       = g_stage[NSLICE-1].s_q;
  assign cout      = g_stage[NSLICE-1].c_q;
  assign ovf       = g_stage[NSLICE-1].g_last.ovf_q;
  assign zero      = g_stage[NSLICE-1].g_last.zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed testbench for cla_pipe_adder with WIDTH=32, so the latency is 2.
// Inputs are driven and outputs sampled 1 ns after each rising edge.

module tb_cla_pipe_adder;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, zero;

  int checks = 0;
  int errors = 0;

  cla_pipe_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] es, input logic ec, input logic eo);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".sum"},   sum, es);
    chk({tag, ".cout"},  {31'd0, cout}, {31'd0, ec});
    chk({tag, ".ovf"},   {31'd0, ovf},  {31'd0, eo});
    chk({tag, ".zero"},  {31'd0, zero}, {31'd0, (es == 32'd0)});
  endtask

  task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb);
    in_valid = v;
    a = av;
    b = bv;
    cin = ci;
    sub = sb;
  endtask

  // Issue one op into an idle pipe, then check the result two cycles later.
  task automatic run_one(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic sb,
                         input logic [31:0] es, input logic ec, input logic eo);
    drive(1'b1, av, bv, ci, sb);
    tick();
    chk({tag, ".lat1"}, {31'd0, out_valid}, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk_res(tag, es, ec, eo);
    tick();
    chk({tag, ".drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [31:0] s_a   [8] = '{32'h00000001, 32'hFFFF0000, 32'h80000000, 32'h00000010,
                            32'h00008000, 32'h00000000, 32'hAAAAAAAA, 32'hAAAAAAAA};
  logic [31:0] s_b   [8] = '{32'h00000002, 32'h00010000, 32'h80000000, 32'h00000010,
                            32'h00008000, 32'h00000001, 32'h55555555, 32'h55555555};
  logic        s_cin [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        s_sub [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] s_sum [8] = '{32'h00000003, 32'h00000000, 32'h00000000, 32'h00000000,
                            32'h00010001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
  logic        s_co  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        s_ov  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset state
    tick();
    tick();
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.sum",   sum, 32'd0);
    chk("rst.flags", {29'd0, cout, ovf, zero}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

    // Single ops and boundaries
    run_one("carry16",  32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0);
    run_one("wrap",     32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_one("ovf_add",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_one("ovf_sub",  32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_one("sub_cin",  32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0);
    run_one("borrow",   32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_one("add_cin",  32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);

    // Back-to-back stream: one result per cycle, in order
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(1'b1, s_a[i], s_b[i], s_cin[i], s_sub[i]);
      else       drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      tick();
      if (i == 0) chk("stream.lat", {31'd0, out_valid}, 32'd0);
      else        chk_res($sformatf("stream%0d", i - 1), s_sum[i-1], s_co[i-1], s_ov[i-1]);
    end
    tick();
    chk("stream.end", {31'd0, out_valid}, 32'd0);

    // Backpressure
    drive(1'b1, 32'd100, 32'd200, 1'b0, 1'b0);              // P0 = 0x12C
    tick();
    drive(1'b1, 32'h0001FFFF, 32'h00000001, 1'b0, 1'b0);    // P1 = 0x00020000
    tick();
    chk_res("bp.p0", 32'h0000012C, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 32'h00001000, 32'h00000001, 1'b0, 1'b1);    // P2 = 0xFFF
    #1;
    chk("bp.in_ready0", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp.stall%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
      chk_res($sformatf("bp.stall%0d", i), 32'h0000012C, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready1", {31'd0, in_ready}, 32'd1);
    tick();
    chk_res("bp.p1", 32'h00020000, 1'b0, 1'b0);
    drive(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);    // P3 = 0
    tick();
    chk_res("bp.p2", 32'h00000FFF, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk_res("bp.p3", 32'h00000000, 1'b1, 1'b0);
    tick();
    chk("bp.end", {31'd0, out_valid}, 32'd0);

    // Reset while ops are in flight
    drive(1'b1, 32'h00000011, 32'h00000022, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h00000033, 32'h00000044, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("mrst.valid0", {31'd0, out_valid}, 32'd0);
    chk("mrst.sum", sum, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mrst.quiet%0d", i), {31'd0, out_valid}, 32'd0);
    end
    run_one("mrst.new", 32'h00001234, 32'h00004321, 1'b0, 1'b0, 32'h00005555, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
